// File: rtl/match_state_ctrl_pkg.sv
// Shared types for the air-hockey match controller.
// Match state encoding and NES button bit positions.
package match_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAY  = 3'd1,
    ST_SERVE = 3'd2,
    ST_PAUSE = 3'd3,
    ST_WIN   = 3'd4
  } state_t;

  // Bit positions in the NES decoder's button vector
  localparam int BTN_A      = 0;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;

endpackage

// File: rtl/match_state_ctrl_if.sv
// Bundle between controller/collision inputs and match controller.
// master: drives buttons/goals/frameTick; slave: drives match status.
interface match_state_ctrl_if #(
  parameter int SCORE_W = 8
);
  import match_pkg::*;

  logic               frameTick;
  logic [1:0]         startBtn;
  logic [1:0]         serveBtn;
  logic [1:0]         pauseBtn;
  logic               goalLeft;
  logic               goalRight;
  state_t             state;
  logic [SCORE_W-1:0] scoreP1;
  logic [SCORE_W-1:0] scoreP2;
  logic               serveSide;
  logic               winner;
  logic               ballReset;

  modport master (
    output frameTick, startBtn, serveBtn,
    output pauseBtn, goalLeft, goalRight,
    input  state, scoreP1, scoreP2,
    input  serveSide, winner, ballReset
  );

  modport slave (
    input  frameTick, startBtn, serveBtn,
    input  pauseBtn, goalLeft, goalRight,
    output state, scoreP1, scoreP2,
    output serveSide, winner, ballReset
  );
endinterface

// File: rtl/match_state_ctrl_frame_edge_detect.sv
// Frame-qualified rising-edge detector: prev latched on each tick.
// Ports: i_clk, i_rst_n, i_tick, i_cur[N] -> o_press[N].
module frame_edge_detect #(
  parameter int N = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_tick,
  input  logic [N-1:0] i_cur,
  output logic [N-1:0] o_press
);
  logic [N-1:0] r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= '0;
    end else if (i_tick) begin
      r_prev <= i_cur;
    end
  end

  assign o_press = i_cur & ~r_prev;
endmodule

// File: rtl/match_state_ctrl.sv
// Two-player match FSM: start, serve, score, pause, win.
// Ports: pixelClock, resetN, bus (slave modport of match_state_ctrl_if).
module match_state_ctrl
  import match_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int SCORE_W      = 8,
  parameter int SERVE_FRAMES = 180,
  parameter int CNT_W        = 16
) (
  input  logic pixelClock,
  input  logic resetN,
  match_state_ctrl_if.slave bus
);
  localparam logic [SCORE_W-1:0] LP_WIN =
    SCORE_W'(WIN_SCORE);
  localparam bit LP_AUTO = (SERVE_FRAMES != 0);
  localparam logic [CNT_W-1:0] LP_LAST =
    LP_AUTO ? CNT_W'(SERVE_FRAMES - 1) : '0;

  logic [1:0] w_start_press;
  logic [1:0] w_serve_press;
  logic [1:0] w_pause_press;
  logic       w_start_ok;
  logic       w_serve_go;
  logic [SCORE_W-1:0] w_p1_inc;
  logic [SCORE_W-1:0] w_p2_inc;

  state_t             r_state;
  logic [SCORE_W-1:0] r_p1;
  logic [SCORE_W-1:0] r_p2;
  logic               r_side;
  logic               r_winner;
  logic               r_ball_reset;
  logic [CNT_W-1:0]   r_cnt;

  frame_edge_detect #(.N(2)) u_start (
    .i_clk   (pixelClock),
    .i_rst_n (resetN),
    .i_tick  (bus.frameTick),
    .i_cur   (bus.startBtn),
    .o_press (w_start_press)
  );

  frame_edge_detect #(.N(2)) u_serve (
    .i_clk   (pixelClock),
    .i_rst_n (resetN),
    .i_tick  (bus.frameTick),
    .i_cur   (bus.serveBtn),
    .o_press (w_serve_press)
  );

  frame_edge_detect #(.N(2)) u_pause (
    .i_clk   (pixelClock),
    .i_rst_n (resetN),
    .i_tick  (bus.frameTick),
    .i_cur   (bus.pauseBtn),
    .o_press (w_pause_press)
  );

  // A fresh press by either player while both are down
  assign w_start_ok = (|w_start_press) & (&bus.startBtn);

  // Only the serving player's A counts
  assign w_serve_go =
    (r_side ? w_serve_press[1] : w_serve_press[0]) |
    (LP_AUTO && (r_cnt == LP_LAST));

  assign w_p1_inc = r_p1 + 1'b1;
  assign w_p2_inc = r_p2 + 1'b1;

  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      r_state      <= ST_IDLE;
      r_p1         <= '0;
      r_p2         <= '0;
      r_side       <= 1'b0;
      r_winner     <= 1'b0;
      r_ball_reset <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_ball_reset <= 1'b0;
      if (bus.frameTick) begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_start_ok) begin
              r_p1         <= '0;
              r_p2         <= '0;
              r_side       <= 1'b0;
              r_ball_reset <= 1'b1;
              r_state      <= ST_PLAY;
            end
          end
          ST_PLAY: begin
            if (bus.goalLeft && bus.goalRight) begin
              r_cnt        <= '0;
              r_ball_reset <= 1'b1;
              r_state      <= ST_SERVE;
            end else if (bus.goalRight) begin
              r_p1   <= w_p1_inc;
              r_side <= 1'b1;
              r_cnt  <= '0;
              if (w_p1_inc == LP_WIN) begin
                r_winner <= 1'b0;
                r_state  <= ST_WIN;
              end else begin
                r_ball_reset <= 1'b1;
                r_state      <= ST_SERVE;
              end
            end else if (bus.goalLeft) begin
              r_p2   <= w_p2_inc;
              r_side <= 1'b0;
              r_cnt  <= '0;
              if (w_p2_inc == LP_WIN) begin
                r_winner <= 1'b1;
                r_state  <= ST_WIN;
              end else begin
                r_ball_reset <= 1'b1;
                r_state      <= ST_SERVE;
              end
            end else if (|w_pause_press) begin
              r_state <= ST_PAUSE;
            end
          end
          ST_SERVE: begin
            if (w_serve_go) begin
              r_state <= ST_PLAY;
            end else if (r_cnt != '1) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_PAUSE: begin
            if (|w_pause_press) begin
              r_state <= ST_PLAY;
            end
          end
          ST_WIN: begin
            if (|w_start_press) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.state     = r_state;
  assign bus.scoreP1   = r_p1;
  assign bus.scoreP2   = r_p2;
  assign bus.serveSide = r_side;
  assign bus.winner    = r_winner;
  assign bus.ballReset = r_ball_reset;
endmodule

// File: tb/tb_match_state_ctrl.sv
// Directed bench for match_state_ctrl.
// WIN_SCORE=3, SERVE_FRAMES=4; hand-computed expectations.
module tb_match_state_ctrl;
  import match_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  match_state_ctrl_if #(.SCORE_W(8)) bus ();

  match_state_ctrl #(
    .WIN_SCORE    (3),
    .SCORE_W      (8),
    .SERVE_FRAMES (4),
    .CNT_W        (16)
  ) dut (
    .pixelClock (clk),
    .resetN     (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One frame: tick high for exactly one rising edge
  task automatic frame();
    @(negedge clk);
    bus.frameTick = 1'b1;
    @(posedge clk);
    #1;
    bus.frameTick = 1'b0;
  endtask

  task automatic chk_st(input string tag,
                        input state_t exp);
    chk(tag, 32'(bus.state), 32'(exp));
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    bus.frameTick = 1'b0;
    bus.startBtn  = 2'b11;
    bus.serveBtn  = 2'b00;
    bus.pauseBtn  = 2'b00;
    bus.goalLeft  = 1'b0;
    bus.goalRight = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_st("rst_state", ST_IDLE);
    chk("rst_p1", 32'(bus.scoreP1), 0);
    chk("rst_ball", 32'(bus.ballReset), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: Start held through reset counts as a press
    frame();
    chk_st("t1_play", ST_PLAY);
    chk("t1_ball", 32'(bus.ballReset), 1);
    chk("t1_p1", 32'(bus.scoreP1), 0);
    chk("t1_p2", 32'(bus.scoreP2), 0);
    frame();
    chk_st("t1_play2", ST_PLAY);
    chk("t1_ball2", 32'(bus.ballReset), 0);
    bus.startBtn = 2'b00;

    // 2: P1 scores, only P2's A serves
    bus.goalRight = 1'b1;
    frame();
    bus.goalRight = 1'b0;
    chk_st("t2_serve", ST_SERVE);
    chk("t2_p1", 32'(bus.scoreP1), 1);
    chk("t2_side", 32'(bus.serveSide), 1);
    chk("t2_ball", 32'(bus.ballReset), 1);
    bus.serveBtn = 2'b01;
    frame();
    chk_st("t2_p1a_ign", ST_SERVE);
    bus.serveBtn = 2'b10;
    frame();
    chk_st("t2_p2a_play", ST_PLAY);
    bus.serveBtn = 2'b00;
    frame();

    // 3: goal beats pause; auto serve after 4 frames
    bus.goalLeft = 1'b1;
    bus.pauseBtn = 2'b01;
    frame();
    bus.goalLeft = 1'b0;
    bus.pauseBtn = 2'b00;
    chk_st("t3_serve", ST_SERVE);
    chk("t3_p2", 32'(bus.scoreP2), 1);
    chk("t3_side", 32'(bus.serveSide), 0);
    for (int i = 1; i <= 3; i++) begin
      frame();
      chk_st($sformatf("t3_wait%0d", i), ST_SERVE);
    end
    frame();
    chk_st("t3_auto", ST_PLAY);
    chk("t3_p2_held", 32'(bus.scoreP2), 1);
    chk("t3_p1_held", 32'(bus.scoreP1), 1);

    // frameTick low: nothing moves
    bus.goalRight = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.goalRight = 1'b0;
    chk_st("notick_state", ST_PLAY);
    chk("notick_p1", 32'(bus.scoreP1), 1);

    // 4: simultaneous goals
    bus.goalLeft  = 1'b1;
    bus.goalRight = 1'b1;
    frame();
    bus.goalLeft  = 1'b0;
    bus.goalRight = 1'b0;
    chk_st("t4_serve", ST_SERVE);
    chk("t4_p1", 32'(bus.scoreP1), 1);
    chk("t4_p2", 32'(bus.scoreP2), 1);
    chk("t4_ball", 32'(bus.ballReset), 1);
    chk("t4_side", 32'(bus.serveSide), 0);
    bus.serveBtn = 2'b01;
    frame();
    chk_st("t4_p1a_play", ST_PLAY);
    bus.serveBtn = 2'b00;
    frame();

    // 5: P1 reaches 3 and wins
    bus.goalRight = 1'b1;
    frame();
    bus.goalRight = 1'b0;
    chk("t5_p1_2", 32'(bus.scoreP1), 2);
    bus.serveBtn = 2'b10;
    frame();
    chk_st("t5_play", ST_PLAY);
    bus.serveBtn = 2'b00;
    frame();
    bus.goalRight = 1'b1;
    frame();
    bus.goalRight = 1'b0;
    chk_st("t5_win", ST_WIN);
    chk("t5_p1_3", 32'(bus.scoreP1), 3);
    chk("t5_winner", 32'(bus.winner), 0);
    bus.goalLeft = 1'b1;
    frame();
    bus.goalLeft = 1'b0;
    chk_st("t5_win_hold", ST_WIN);
    chk("t5_p2_ign", 32'(bus.scoreP2), 1);
    bus.startBtn = 2'b01;
    frame();
    chk_st("t5_idle", ST_IDLE);
    frame();
    chk_st("t5_no_restart", ST_IDLE);
    bus.startBtn = 2'b00;
    frame();

    // 6: pause, goals ignored, async reset mid-pause
    bus.startBtn = 2'b11;
    frame();
    bus.startBtn = 2'b00;
    chk_st("t6_play", ST_PLAY);
    chk("t6_p1_clr", 32'(bus.scoreP1), 0);
    bus.goalRight = 1'b1;
    frame();
    bus.goalRight = 1'b0;
    bus.serveBtn = 2'b10;
    frame();
    bus.serveBtn = 2'b00;
    chk_st("t6_served", ST_PLAY);
    chk("t6_p1_1", 32'(bus.scoreP1), 1);
    bus.pauseBtn = 2'b10;
    frame();
    bus.pauseBtn = 2'b00;
    chk_st("t6_pause", ST_PAUSE);
    bus.goalLeft = 1'b1;
    frame();
    bus.goalLeft = 1'b0;
    chk_st("t6_pause_goal", ST_PAUSE);
    chk("t6_p2_frozen", 32'(bus.scoreP2), 0);
    bus.pauseBtn = 2'b10;
    frame();
    bus.pauseBtn = 2'b00;
    chk_st("t6_resume", ST_PLAY);
    frame();
    bus.pauseBtn = 2'b01;
    frame();
    bus.pauseBtn = 2'b00;
    chk_st("t6_pause2", ST_PAUSE);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_st("t6_rst_idle", ST_IDLE);
    chk("t6_rst_p1", 32'(bus.scoreP1), 0);
    chk("t6_rst_side", 32'(bus.serveSide), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
